// File: rtl/ram_rw_pkg.sv
// Purpose : shared types and limits for the RAM read/write engine.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package ram_rw_pkg;

    // Request direction, keeping the legacy RWn polarity (1 = read).
    typedef enum logic {
        RWN_WRITE = 1'b0,
        RWN_READ  = 1'b1
    } rwn_e;

    // Deepest read pipeline the engine is built for.
    localparam int RD_LAT_MAX = 4;

endpackage

// File: rtl/ram_rsp_fifo.sv
// Purpose : synchronous response FIFO with occupancy count, show-ahead head word.
// Latency : push visible at the output the cycle after the pushing edge.
// Backpressure: push accepted when not full or when a pop happens in the same cycle.
module ram_rsp_fifo #(
    parameter int  WIDTH = 9,
    parameter int  DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_dat,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_pop_dat,
    output logic [CNT_W-1:0] o_count,
    output logic             o_full,
    output logic             o_empty
);

    localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CNT_FULL);
    assign w_pop_ok  = i_pop & ~o_empty;
    // A full FIFO may still take a word when the head leaves on the same edge.
    assign w_push_ok = i_push & (~o_full | w_pop_ok);
    assign o_pop_dat = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    // Storage is not reset; only pointers and count define what is valid.
    always_ff @(posedge i_clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_push_dat;
        end
    end

    // Pointer and occupancy bookkeeping, pointers wrap at DEPTH.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + 1'b1;
            end
            r_count <= r_count + CNT_W'(w_push_ok) - CNT_W'(w_pop_ok);
        end
    end

endmodule

// File: rtl/ram_rw_engine.sv
// Purpose : single-port RAM behind a valid/ready request channel with buffered, in-order read responses.
// Latency : read data enters the response FIFO RD_LAT cycles after the accepting edge; writes take effect at that edge.
// Backpressure: req_ready drops once pipeline reads plus buffered responses reach RSP_DEPTH (a same-cycle pop frees a slot).
module ram_rw_engine
    import ram_rw_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8,
    parameter int DEPTH     = 2 ** ADDR_W,
    parameter int RD_LAT    = 1,
    parameter int RSP_DEPTH = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_rwn,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [DATA_W-1:0] i_req_wdata,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [DATA_W-1:0] o_rsp_rdata,
    output logic              o_rsp_err,
    output logic              o_busy
);

    typedef struct packed {
        logic              err;
        logic [DATA_W-1:0] data;
    } rsp_t;

    localparam int               CNT_W   = $clog2(RSP_DEPTH) + 1;
    localparam int               MEM_AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]  DEPTH_C = (ADDR_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] CREDITS = CNT_W'(RSP_DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic              r_run;
    logic [CNT_W-1:0]  r_outstanding;
    logic [RD_LAT-1:0] r_pipe_vld;
    rsp_t              r_pipe_dat [RD_LAT];

    logic              w_accept;
    logic              w_rd_acc;
    logic              w_wr_acc;
    logic              w_in_range;
    logic [MEM_AW-1:0] w_mem_idx;
    rsp_t              w_rd_sample;
    rsp_t              w_head;
    logic              w_pop;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic [CNT_W-1:0]  w_fifo_count;
    logic [CNT_W-1:0]  w_credit_used;

    assign w_accept   = i_req_valid & o_req_ready;
    assign w_rd_acc   = w_accept & (rwn_e'(i_req_rwn) == RWN_READ);
    assign w_wr_acc   = w_accept & (rwn_e'(i_req_rwn) == RWN_WRITE);
    assign w_in_range = ({1'b0, i_req_addr} < DEPTH_C);
    assign w_mem_idx  = i_req_addr[MEM_AW-1:0];

    // Every accepted read owns a FIFO slot from acceptance until it is popped,
    // so the FIFO can never overflow. A pop on this edge releases its slot now.
    assign w_credit_used = r_outstanding - CNT_W'(w_pop);
    assign o_req_ready   = r_run & (w_credit_used < CREDITS);

    assign o_rsp_valid = ~w_fifo_empty;
    assign w_pop       = o_rsp_valid & i_rsp_ready;
    assign o_rsp_rdata = o_rsp_valid ? w_head.data : '0;
    assign o_rsp_err   = o_rsp_valid & w_head.err;
    assign o_busy      = (r_outstanding != '0);

    // Read sample: out-of-range reads return zero data flagged as an error.
    always_comb begin
        w_rd_sample     = '0;
        w_rd_sample.err = ~w_in_range;
        if (w_in_range) begin
            w_rd_sample.data = r_mem[w_mem_idx];
        end
    end

    // RAM write port; out-of-range writes are dropped, contents survive reset.
    always_ff @(posedge i_clk) begin
        if (w_wr_acc && w_in_range) begin
            r_mem[w_mem_idx] <= i_req_wdata;
        end
    end

    // Hold off requests until the first edge after reset release.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_run <= 1'b0;
        end else begin
            r_run <= 1'b1;
        end
    end

    // Reads in flight plus buffered responses.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_outstanding <= '0;
        end else begin
            r_outstanding <= r_outstanding + CNT_W'(w_rd_acc) - CNT_W'(w_pop);
        end
    end

    // Read pipeline valid bits; reset discards anything in flight.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pipe_vld <= '0;
        end else begin
            r_pipe_vld[0] <= w_rd_acc;
            for (int i = 1; i < RD_LAT; i++) begin
                r_pipe_vld[i] <= r_pipe_vld[i-1];
            end
        end
    end

    // Read pipeline payload; only meaningful where the matching valid bit is set.
    always_ff @(posedge i_clk) begin
        r_pipe_dat[0] <= w_rd_sample;
        for (int i = 1; i < RD_LAT; i++) begin
            r_pipe_dat[i] <= r_pipe_dat[i-1];
        end
    end

    ram_rsp_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_push     (r_pipe_vld[RD_LAT-1]),
        .i_push_dat (r_pipe_dat[RD_LAT-1]),
        .i_pop      (w_pop),
        .o_pop_dat  (w_head),
        .o_count    (w_fifo_count),
        .o_full     (w_fifo_full),
        .o_empty    (w_fifo_empty)
    );

    a_cfg_legal: assert property (@(posedge i_clk)
        (RD_LAT >= 1) && (RD_LAT <= RD_LAT_MAX) && (RSP_DEPTH >= RD_LAT));

    a_req_stable: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        (i_req_valid && !o_req_ready) |=>
        (i_req_valid && $stable(i_req_rwn) && $stable(i_req_addr) && $stable(i_req_wdata)));

    a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        (w_fifo_full && r_pipe_vld[RD_LAT-1]) |-> w_pop);

    a_credit_covers_fifo: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        (w_fifo_count <= r_outstanding) && (r_outstanding <= CREDITS));

endmodule
